// File: rtl/demux8_1to3_reg_pkg.sv
//------------------------------------------------------------------------------
// Module  : demux8_1to3_reg_pkg
// Brief   : Shared select codes, FSM encodings and helpers for demux8_1to3_reg.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package demux8_1to3_reg_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_Q1   = 2'b01;
    localparam logic [1:0] SEL_Q2   = 2'b10;
    localparam logic [1:0] SEL_Q3   = 2'b11;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    localparam int unsigned NUM_DEST = 3;

    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        oh = 3'b000;
        case (sel)
            SEL_Q1:  oh = 3'b001;
            SEL_Q2:  oh = 3'b010;
            SEL_Q3:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg8_en.sv
//------------------------------------------------------------------------------
// Module  : reg8_en
// Brief   : WIDTH-bit register with synchronous active-high reset and load enable.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg8_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/demux8_1to3_reg.sv
//------------------------------------------------------------------------------
// Module  : demux8_1to3_reg
// Brief   : Handshaked 1-to-3 register demux; optional write counter enabled
//           by defining DEMUX8_1TO3_REG_WRCNT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux8_1to3_reg
    import demux8_1to3_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       S,
    input  logic             VALID,
    output logic             READY,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [2:0]       WE,
`ifdef DEMUX8_1TO3_REG_WRCNT_EN
    output logic [7:0]       WR_CNT,
`endif
    output logic             DONE
);

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_sel;
    logic             w_accept;
    logic             w_commit;
    logic [WIDTH-1:0] w_q [NUM_DEST];

    assign w_accept = (r_state == ST_IDLE) && VALID && (S != SEL_NONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_COMMIT;
            ST_COMMIT: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Commit strobes are masked by reset so an aborted write leaves no trace.
    always_comb begin
        READY    = (r_state == ST_IDLE);
        w_commit = (r_state == ST_COMMIT) && !RST;
        WE       = w_commit ? sel_onehot(r_sel) : 3'b000;
        DONE     = w_commit;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data <= '0;
            r_sel  <= SEL_NONE;
        end else if (w_accept) begin
            r_data <= D;
            r_sel  <= S;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_dest
            reg8_en #(
                .WIDTH (WIDTH)
            ) u_reg (
                .clk  (CLK),
                .rst  (RST),
                .i_en (WE[gi]),
                .i_d  (r_data),
                .o_q  (w_q[gi])
            );
        end
    endgenerate

    assign Q1 = w_q[0];
    assign Q2 = w_q[1];
    assign Q3 = w_q[2];

`ifdef DEMUX8_1TO3_REG_WRCNT_EN
    logic [7:0] r_wr_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_cnt <= 8'd0;
        end else if (w_commit && (r_wr_cnt != 8'hFF)) begin
            r_wr_cnt <= r_wr_cnt + 8'd1;
        end
    end

    assign WR_CNT = r_wr_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux8_1to3_reg.sv
//------------------------------------------------------------------------------
// Module  : tb_demux8_1to3_reg
// Brief   : Self-checking bench for demux8_1to3_reg.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux8_1to3_reg;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic [1:0] s;
    logic       valid;
    logic       ready;
    logic [7:0] q1, q2, q3;
    logic [2:0] we;
    logic       done;
`ifdef DEMUX8_1TO3_REG_WRCNT_EN
    logic [7:0] wr_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    demux8_1to3_reg #(.WIDTH(8)) dut (
        .CLK    (clk),
        .RST    (rst),
        .D      (d),
        .S      (s),
        .VALID  (valid),
        .READY  (ready),
        .Q1     (q1),
        .Q2     (q2),
        .Q3     (q3),
        .WE     (we),
`ifdef DEMUX8_1TO3_REG_WRCNT_EN
        .WR_CNT (wr_cnt),
`endif
        .DONE   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [1:0] s;
        logic [7:0] d;
        logic       ready;
        logic [2:0] we;
        logic       done;
        logic [7:0] q1;
        logic [7:0] q2;
        logic [7:0] q3;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef DEMUX8_1TO3_REG_WRCNT_EN
    task automatic write_one(input logic [1:0] sel, input logic [7:0] data);
        int waited;
        waited = 0;
        while (!ready && waited < 10) begin
            step();
            waited++;
        end
        if (!ready) check("ready_timeout", 0, 1);
        rst = 1'b0; valid = 1'b1; s = sel; d = data;
        step();
        valid = 1'b0;
        step();
    endtask
`endif

    initial begin
        int accepts;
        int dones;

        // Each row: inputs for this cycle, outputs expected before the edge.
        //           rst   vld   s      d      rdy   we      dn    q1     q2     q3
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 2'b01, 8'hA5, 1'b1, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 3'b001, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 3'b000, 1'b0, 8'hA5, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 2'b10, 8'h11, 1'b1, 3'b000, 1'b0, 8'hA5, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 2'b11, 8'h22, 1'b0, 3'b010, 1'b1, 8'hA5, 8'h00, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 2'b11, 8'h22, 1'b1, 3'b000, 1'b0, 8'hA5, 8'h11, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 3'b100, 1'b1, 8'hA5, 8'h11, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 8'hFF, 1'b1, 3'b000, 1'b0, 8'hA5, 8'h11, 8'h22};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 3'b000, 1'b0, 8'hA5, 8'h11, 8'h22};
        vecs[10] = '{1'b0, 1'b1, 2'b01, 8'h33, 1'b1, 3'b000, 1'b0, 8'hA5, 8'h11, 8'h22};
        vecs[11] = '{1'b0, 1'b0, 2'b01, 8'h77, 1'b0, 3'b001, 1'b1, 8'hA5, 8'h11, 8'h22};
        vecs[12] = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 3'b000, 1'b0, 8'h33, 8'h11, 8'h22};
        vecs[13] = '{1'b0, 1'b1, 2'b11, 8'h5A, 1'b1, 3'b000, 1'b0, 8'h33, 8'h11, 8'h22};
        vecs[14] = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 3'b000, 1'b0, 8'h33, 8'h11, 8'h22};
        vecs[15] = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[16] = '{1'b1, 1'b1, 2'b01, 8'hAA, 1'b1, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[17] = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[18] = '{1'b0, 1'b1, 2'b01, 8'h01, 1'b1, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[19] = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 3'b001, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[20] = '{1'b0, 1'b1, 2'b01, 8'h02, 1'b1, 3'b000, 1'b0, 8'h01, 8'h00, 8'h00};
        vecs[21] = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 3'b001, 1'b1, 8'h01, 8'h00, 8'h00};
        vecs[22] = '{1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 3'b000, 1'b0, 8'h02, 8'h00, 8'h00};

        rst = 1'b1; valid = 1'b0; s = 2'b00; d = 8'h00;
        step();
        step();

        for (int i = 0; i < NVEC; i++) begin
            rst   = vecs[i].rst;
            valid = vecs[i].valid;
            s     = vecs[i].s;
            d     = vecs[i].d;
            #1;
            check($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].ready));
            check($sformatf("v%0d_we",    i), 32'(we),    32'(vecs[i].we));
            check($sformatf("v%0d_done",  i), 32'(done),  32'(vecs[i].done));
            check($sformatf("v%0d_q1",    i), 32'(q1),    32'(vecs[i].q1));
            check($sformatf("v%0d_q2",    i), 32'(q2),    32'(vecs[i].q2));
            check($sformatf("v%0d_q3",    i), 32'(q3),    32'(vecs[i].q3));
            step();
        end

        // Held-high VALID: accepts land every other cycle over six cycles.
        rst = 1'b0; valid = 1'b1; s = 2'b10; d = 8'h44;
        accepts = 0;
        dones   = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (ready && valid) accepts++;
            if (done) dones++;
            step();
        end
        valid = 1'b0;
        #1;
        check("held_accepts", 32'(accepts), 32'd3);
        check("held_dones",   32'(dones),   32'd3);
        check("held_q2",      32'(q2),      32'h44);
        check("held_q1",      32'(q1),      32'h02);
        check("held_ready",   32'(ready),   32'd1);

`ifdef DEMUX8_1TO3_REG_WRCNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("cnt_reset", 32'(wr_cnt), 32'd0);
        for (int k = 1; k <= 257; k++) begin
            write_one(2'b11, 8'(k));
            if (k == 1)   check("cnt_1",   32'(wr_cnt), 32'd1);
            if (k == 254) check("cnt_254", 32'(wr_cnt), 32'd254);
            if (k == 256) check("cnt_256", 32'(wr_cnt), 32'd255);
            if (k == 257) check("cnt_257", 32'(wr_cnt), 32'd255);
        end
        check("cnt_q3", 32'(q3), 32'h01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("cnt_rst", 32'(wr_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux8_1to3_reg.md
DEMUX8_1TO3_REG -- requirements
Module: demux8_1to3_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data width of D and Q1..Q3.
REQ-002 SHALL provide CLK  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL provide RST  input  1  reset; reset is synchronous and active-high.
REQ-004 SHALL provide D  input  WIDTH  write data from the shared bus.
REQ-005 SHALL provide S  input  2  destination select; 2'b01=Q1, 2'b10=Q2, 2'b11=Q3, 2'b00=no destination.
REQ-006 SHALL provide VALID  input  1  requester has D/S stable for transfer.
REQ-007 SHALL provide READY  output  1  block can accept a transfer this cycle.
REQ-008 SHALL provide Q1, Q2, Q3  output  WIDTH each  held destination register contents.
REQ-009 SHALL provide WE  output  3  one-hot commit strobe, bit n-1 for Qn.
REQ-010 SHALL provide DONE  output  1  one-cycle pulse when a write commits.

Function
REQ-011 SHALL accept a transfer on a rising edge where VALID=1 and READY=1.
REQ-012 SHALL implement FSM states IDLE and COMMIT; READY=1 only in IDLE.
REQ-013 IDLE: accept with S!=00 SHALL capture D and S into holding registers and go to COMMIT.
REQ-014 IDLE: accept with S=00 SHALL discard the transfer, stay in IDLE, and alter no output.
REQ-015 COMMIT SHALL write the held data into the selected Qn, drive WE one-hot and DONE=1 for that cycle, then return to IDLE.
REQ-016 Latency: Qn SHALL show new data after the edge following the accept edge; maximum throughput one write per 2 cycles.
REQ-017 Non-selected Qn SHALL hold their value through every transfer.
REQ-018 Changes on D/S while READY=0 SHALL be ignored; a held-high VALID SHALL be accepted on the first IDLE cycle.
REQ-019 WE and DONE SHALL be 0 in IDLE.
REQ-020 Back-to-back writes to the same Qn SHALL leave the last accepted value.

Reset
REQ-021 RST=1 at a rising edge SHALL force IDLE, Q1=Q2=Q3=0, WE=0, DONE=0, and clear the holding registers.
REQ-022 RST SHALL override VALID; no transfer is accepted in a reset cycle.
REQ-023 RST asserted while in COMMIT SHALL abort the write; no Qn is updated and DONE is not pulsed.
REQ-024 READY SHALL be 1 in the first cycle after RST deasserts.

Configuration
REQ-025 With DEMUX8_1TO3_REG_WRCNT_EN defined, the block SHALL add output WR_CNT [7:0], reset to 0 and incremented on each DONE.
REQ-026 WR_CNT SHALL saturate at 255 and never wrap.
REQ-027 Without DEMUX8_1TO3_REG_WRCNT_EN, the WR_CNT port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 Select codes (SEL_NONE=00, SEL_Q1=01, SEL_Q2=10, SEL_Q3=11) and FSM state encodings SHALL live in the shared CPU definitions package.
REQ-029 Each destination SHALL be an instance of sub-module reg8_en, a WIDTH-bit register with synchronous reset and load enable.

Verification
REQ-030 Reset then write D=8'hA5, S=01: READY drops one cycle, then Q1=A5, WE=001, DONE=1 for one cycle, and Q2=Q3=00.
REQ-031 Writes 8'h11 to S=10 then 8'h22 to S=11 with VALID held high: accepts are 2 cycles apart, giving Q2=11 and Q3=22 with Q1 unchanged.
REQ-032 VALID=1 with S=00 and D=8'hFF: READY stays 1, Q1..Q3, WE, and DONE are unchanged.
REQ-033 Accept D=8'h5A, S=11, then assert RST in COMMIT: Q3=00, DONE never pulses, and READY=1 after release.
REQ-034 Change D to 8'h77 in the COMMIT cycle after accepting 8'h33 to Q1: Q1=33.
REQ-035 With WRCNT_EN, 256 writes give WR_CNT=255 and a 257th write keeps 255; RST returns it to 0.
